// File: rtl/request_handler_pkg.sv
// Shared sensor request protocol definitions.
// - state_t    : request handler FSM states
// - ERR_*      : error_code values reported on request_error
// - REQ_CODE_* : request code range limits (default legal range 0x00..0x06)
// - SENSOR_ADDR_MAX_DEFAULT : default highest legal sensor address
package request_handler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_ADDR = 2'b01,
    ST_CHECK     = 2'b10,
    ST_ISSUE     = 2'b11
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_BAD_CODE = 2'b01;
  localparam logic [1:0] ERR_BAD_ADDR = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam logic [7:0] REQ_CODE_MIN            = 8'h00;
  localparam logic [7:0] REQ_CODE_MAX_DEFAULT    = 8'h06;
  localparam logic [7:0] SENSOR_ADDR_MAX_DEFAULT = 8'h1F;

endpackage

// File: rtl/request_handler_timeout_counter.sv
// Inter-byte timeout counter.
// Ports:
//   clock   : rising-edge clock
//   reset   : synchronous active-high reset, clears the count
//   clear   : restart the count from zero
//   enable  : advance the count by one this cycle
//   expired : count has reached TIMEOUT_CYCLES-1
// The count saturates at TIMEOUT_CYCLES-1 and never wraps.
module timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expired = (count == LAST);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/request_handler.sv
// Two-byte request parser between a UART receiver and sensor logic.
// First rx_done byte is the request code, second is the sensor address.
// The pair is range-checked and then presented downstream.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   rx_done, rx_data      : single-cycle byte strobe and byte from the UART
//   request_ack           : downstream accepts the presented request
//   request_valid         : request_code/sensor_address valid
//   request_code          : validated request code
//   sensor_address        : validated sensor address
//   request_error         : single-cycle error strobe
//   error_code            : last error (see ERR_* in the package)
//   busy                  : FSM is not in IDLE
//   fsm_state             : current FSM state, for observation
// Handshake: a request transfers on a rising edge where request_valid and
// request_ack are both high. Once raised, request_valid, request_code and
// sensor_address stay unchanged until that transfer; request_ack is
// ignored while request_valid is low.
module request_handler
  import request_handler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter logic [7:0]  MAX_CODE       = REQ_CODE_MAX_DEFAULT,
  parameter logic [7:0]  MAX_ADDRESS    = SENSOR_ADDR_MAX_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       request_ack,
  output logic       request_valid,
  output logic [7:0] request_code,
  output logic [7:0] sensor_address,
  output logic       request_error,
  output logic [1:0] error_code,
  output logic       busy,
  output state_t     fsm_state
);

  state_t     state;
  logic [7:0] code_q;
  logic [7:0] addr_q;
  logic       timer_clear;
  logic       timer_enable;
  logic       timer_expired;

  // Count only the idle cycles between the two bytes; a cycle carrying the
  // second byte is never counted, so a byte on the expiry cycle wins.
  assign timer_clear  = (state == ST_IDLE) && rx_done;
  assign timer_enable = (state == ST_WAIT_ADDR) && !rx_done;
  assign fsm_state    = state;

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      code_q         <= 8'h00;
      addr_q         <= 8'h00;
      request_valid  <= 1'b0;
      request_code   <= 8'h00;
      sensor_address <= 8'h00;
      request_error  <= 1'b0;
      error_code     <= ERR_NONE;
      busy           <= 1'b0;
    end else begin
      request_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_done) begin
            code_q <= rx_data;
            state  <= ST_WAIT_ADDR;
            busy   <= 1'b1;
          end
        end
        ST_WAIT_ADDR: begin
          if (rx_done) begin
            addr_q <= rx_data;
            state  <= ST_CHECK;
          end else if (timer_expired) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            request_error <= 1'b1;
            error_code    <= ERR_TIMEOUT;
          end
        end
        ST_CHECK: begin
          // Bad code is reported in preference to bad address.
          if (code_q > MAX_CODE) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            request_error <= 1'b1;
            error_code    <= ERR_BAD_CODE;
          end else if (addr_q > MAX_ADDRESS) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            request_error <= 1'b1;
            error_code    <= ERR_BAD_ADDR;
          end else begin
            state          <= ST_ISSUE;
            request_code   <= code_q;
            sensor_address <= addr_q;
          end
        end
        ST_ISSUE: begin
          // request_valid rises one cycle after entering ISSUE, giving the
          // two-edge latency from the second byte.
          if (request_valid && request_ack) begin
            request_valid <= 1'b0;
            state         <= ST_IDLE;
            busy          <= 1'b0;
          end else begin
            request_valid <= 1'b1;
          end
        end
        default: begin
          state         <= ST_IDLE;
          request_valid <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_request_handler.sv
module tb_request_handler;
  import request_handler_pkg::*;

  localparam int TO = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       request_ack;
  logic       request_valid;
  logic [7:0] request_code;
  logic [7:0] sensor_address;
  logic       request_error;
  logic [1:0] error_code;
  logic       busy;
  state_t     fsm_state;

  int checks = 0;
  int errors = 0;

  request_handler #(
    .TIMEOUT_CYCLES(TO),
    .MAX_CODE      (8'h06),
    .MAX_ADDRESS   (8'h1F)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .rx_done        (rx_done),
    .rx_data        (rx_data),
    .request_ack    (request_ack),
    .request_valid  (request_valid),
    .request_code   (request_code),
    .sensor_address (sensor_address),
    .request_error  (request_error),
    .error_code     (error_code),
    .busy           (busy),
    .fsm_state      (fsm_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] code;
    logic [7:0] addr;
    logic       ok;
    logic [1:0] err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; the byte is sampled on the following posedge.
  task automatic pulse(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clock);
    rx_done = 1'b0;
  endtask

  // Watch n negedges; k counts edges after the call point.
  task automatic observe(input int n, output int v_cnt, output int v_first,
                         output int e_cnt, output int e_first);
    v_cnt = 0; v_first = 0; e_cnt = 0; e_first = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      if (request_valid === 1'b1) begin
        v_cnt++;
        if (v_first == 0) v_first = k;
      end
      if (request_error === 1'b1) begin
        e_cnt++;
        if (e_first == 0) e_first = k;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(request_valid), 32'h0);
    check({tag, "_code"},  32'(request_code), 32'h0);
    check({tag, "_addr"},  32'(sensor_address), 32'h0);
    check({tag, "_error"}, 32'(request_error), 32'h0);
    check({tag, "_ecode"}, 32'(error_code), 32'h0);
    check({tag, "_busy"},  32'(busy), 32'h0);
    check({tag, "_state"}, 32'(fsm_state), 32'(ST_IDLE));
  endtask

  initial begin
    int vc, vf, ec, ef;
    logic [1:0] last_err;

    vecs[0] = '{8'h03, 8'h05, 1'b1, 2'b00};
    vecs[1] = '{8'h07, 8'h05, 1'b0, 2'b01};
    vecs[2] = '{8'h02, 8'h20, 1'b0, 2'b10};
    vecs[3] = '{8'h09, 8'h40, 1'b0, 2'b01};
    vecs[4] = '{8'h06, 8'h1F, 1'b1, 2'b00};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 2'b00};
    vecs[6] = '{8'hFF, 8'h1F, 1'b0, 2'b01};
    vecs[7] = '{8'h06, 8'h20, 1'b0, 2'b10};
    vecs[8] = '{8'h05, 8'h1F, 1'b1, 2'b00};

    reset = 1'b1; rx_done = 1'b0; rx_data = 8'h00; request_ack = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_values("por");
    reset = 1'b0;
    request_ack = 1'b1;
    last_err = 2'b00;
    @(negedge clock);

    // Table-driven byte pairs, ack held high throughout.
    for (int i = 0; i < 9; i++) begin
      pulse(vecs[i].code);
      pulse(vecs[i].addr);
      observe(6, vc, vf, ec, ef);
      if (vecs[i].ok) begin
        check($sformatf("v%0d_valid_cnt", i), 32'(vc), 32'd1);
        check($sformatf("v%0d_valid_lat", i), 32'(vf), 32'd2);
        check($sformatf("v%0d_err_cnt", i), 32'(ec), 32'd0);
        check($sformatf("v%0d_code", i), 32'(request_code), 32'(vecs[i].code));
        check($sformatf("v%0d_addr", i), 32'(sensor_address), 32'(vecs[i].addr));
        check($sformatf("v%0d_ecode_hold", i), 32'(error_code), 32'(last_err));
      end else begin
        check($sformatf("v%0d_valid_cnt", i), 32'(vc), 32'd0);
        check($sformatf("v%0d_err_cnt", i), 32'(ec), 32'd1);
        check($sformatf("v%0d_err_lat", i), 32'(ef), 32'd1);
        check($sformatf("v%0d_ecode", i), 32'(error_code), 32'(vecs[i].err));
        last_err = vecs[i].err;
      end
      check($sformatf("v%0d_busy_after", i), 32'(busy), 32'h0);
      check($sformatf("v%0d_state_after", i), 32'(fsm_state), 32'(ST_IDLE));
    end

    // Timeout: first byte then silence, error on the 16th edge.
    pulse(8'h01);
    observe(TO - 1, vc, vf, ec, ef);
    check("to_no_early_err", 32'(ec), 32'd0);
    check("to_busy_before", 32'(busy), 32'h1);
    observe(1, vc, vf, ec, ef);
    check("to_err_at_16", 32'(ec), 32'd1);
    check("to_ecode", 32'(error_code), 32'(ERR_TIMEOUT));
    check("to_busy_after", 32'(busy), 32'h0);
    observe(3, vc, vf, ec, ef);
    check("to_single_pulse", 32'(ec), 32'd0);
    check("to_no_valid", 32'(vc), 32'd0);
    last_err = ERR_TIMEOUT;

    // Second byte sampled on the expiry edge wins.
    pulse(8'h01);
    repeat (TO - 1) @(negedge clock);
    pulse(8'h05);
    observe(6, vc, vf, ec, ef);
    check("win_err_cnt", 32'(ec), 32'd0);
    check("win_valid_cnt", 32'(vc), 32'd1);
    check("win_valid_lat", 32'(vf), 32'd2);
    check("win_code", 32'(request_code), 32'h01);
    check("win_addr", 32'(sensor_address), 32'h05);
    check("win_ecode_hold", 32'(error_code), 32'(last_err));

    // Pending request with ack low, extra bytes dropped.
    request_ack = 1'b0;
    pulse(8'h03);
    pulse(8'h05);
    observe(2, vc, vf, ec, ef);
    check("hold_valid_rise", 32'(vf), 32'd2);
    for (int i = 0; i < 10; i++) begin
      rx_done = (i % 2 == 1);
      rx_data = 8'hA0 + 8'(i);
      @(negedge clock);
      rx_done = 1'b0;
      check($sformatf("hold%0d_valid", i), 32'(request_valid), 32'h1);
      check($sformatf("hold%0d_code", i), 32'(request_code), 32'h03);
      check($sformatf("hold%0d_addr", i), 32'(sensor_address), 32'h05);
      check($sformatf("hold%0d_err", i), 32'(request_error), 32'h0);
    end
    check("hold_ecode", 32'(error_code), 32'(last_err));
    request_ack = 1'b1;
    @(negedge clock);
    check("ack_valid_low", 32'(request_valid), 32'h0);
    check("ack_busy_low", 32'(busy), 32'h0);
    @(negedge clock);
    check("ack_state_idle", 32'(fsm_state), 32'(ST_IDLE));

    // Reset in WAIT_ADDR, with rx_done in the same cycle.
    pulse(8'h02);
    repeat (3) @(negedge clock);
    check("wa_state_before", 32'(fsm_state), 32'(ST_WAIT_ADDR));
    reset = 1'b1; rx_done = 1'b1; rx_data = 8'h05;
    @(negedge clock);
    rx_done = 1'b0;
    check_reset_values("rst_wa");
    reset = 1'b0;
    observe(TO + 4, vc, vf, ec, ef);
    check("rst_wa_no_err", 32'(ec), 32'd0);
    check("rst_wa_no_valid", 32'(vc), 32'd0);

    // Make error_code nonzero, then reset while ISSUE is pending.
    pulse(8'h09);
    pulse(8'h01);
    observe(3, vc, vf, ec, ef);
    check("pre_rst_ecode", 32'(error_code), 32'(ERR_BAD_CODE));
    request_ack = 1'b0;
    pulse(8'h04);
    pulse(8'h10);
    observe(2, vc, vf, ec, ef);
    check("is_valid_before", 32'(vc), 32'd1);
    reset = 1'b1; request_ack = 1'b1;
    @(negedge clock);
    check_reset_values("rst_is");
    reset = 1'b0;
    observe(5, vc, vf, ec, ef);
    check("rst_is_no_err", 32'(ec), 32'd0);
    check("rst_is_no_valid", 32'(vc), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/request_handler.md
REQUEST_HANDLER -- requirements
Module: request_handler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, meaning maximum clock cycles allowed between first and second request byte (1 s at 50 MHz).
REQ-002 SHALL have parameter MAX_CODE, default 8'h06, meaning highest legal request code.
REQ-003 SHALL have parameter MAX_ADDRESS, default 8'h1F, meaning highest legal sensor address.
REQ-004 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rx_done  input  1  single-cycle strobe from UART receiver: rx_data valid.
REQ-007 SHALL have port rx_data  input  8  received byte.
REQ-008 SHALL have port request_ack  input  1  downstream sensor logic accepts request.
REQ-009 SHALL have port request_valid  output  1  request_code/sensor_address valid; held until accepted.
REQ-010 SHALL have port request_code  output  8  validated request code.
REQ-011 SHALL have port sensor_address  output  8  validated sensor address.
REQ-012 SHALL have port request_error  output  1  single-cycle error strobe.
REQ-013 SHALL have port error_code  output  2  00 none, 01 bad code, 10 bad address, 11 timeout.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_ADDR, CHECK, ISSUE.
REQ-016 IDLE: rx_done -> capture rx_data into code register, clear timeout counter, go WAIT_ADDR.
REQ-017 WAIT_ADDR: rx_done -> capture rx_data into address register, go CHECK; otherwise increment timeout counter.
REQ-018 WAIT_ADDR: counter reaching TIMEOUT_CYCLES-1 without rx_done -> IDLE, request_error pulse, error_code 11.
REQ-019 rx_done in the same cycle as timeout expiry SHALL win: byte captured, no error.
REQ-020 CHECK (one cycle): code > MAX_CODE -> IDLE, error 01; else address > MAX_ADDRESS -> IDLE, error 10; else ISSUE.
REQ-021 Bad code SHALL take priority over bad address when both are illegal.
REQ-022 request_valid SHALL rise on the second rising edge after the edge sampling the second rx_done (2-cycle latency).
REQ-023 ISSUE: request_valid, request_code, sensor_address held stable until request_valid && request_ack sampled; then request_valid low next cycle, go IDLE.
REQ-024 request_ack outside ISSUE SHALL be ignored.
REQ-025 rx_done during CHECK or ISSUE SHALL be dropped (no state change, no capture, no error).
REQ-026 request_error SHALL be high exactly one cycle per error; error_code SHALL hold last error value until next error or reset.
REQ-027 Timeout counter SHALL be sized ceil(log2(TIMEOUT_CYCLES)) bits and SHALL saturate, never wrap.

Reset
REQ-028 reset SHALL force IDLE, request_valid 0, request_code 8'h00, sensor_address 8'h00, request_error 0, error_code 00, busy 0, counter 0.
REQ-029 reset mid-transaction (any state) SHALL abandon the partial request with no error strobe.
REQ-030 reset SHALL dominate rx_done and request_ack in the same cycle.

Structure
REQ-031 State encoding, error_code constants, and request-code constants SHALL live in the shared sensor protocol package.
REQ-032 Inter-byte timeout SHALL be a sub-module timeout_counter (inputs clear, enable; output expired).
REQ-033 All outputs SHALL be registered.

Verification
REQ-034 Bytes 8'h03 then 8'h05, ack held high -> request_valid one cycle, code 03, address 05, busy low after.
REQ-035 Bytes 8'h07 then 8'h05 -> request_error one cycle, error_code 01, no request_valid.
REQ-036 Bytes 8'h02 then 8'h20 -> error_code 10; bytes 8'h09 then 8'h40 -> error_code 01.
REQ-037 Byte 8'h01 then silence, TIMEOUT_CYCLES=16 -> error 11 after 16 cycles; second byte on cycle 16 exactly -> no error, request issued.
REQ-038 Request pending with ack low 10 cycles plus extra rx_done strobes -> outputs stable, bytes dropped; ack -> IDLE.
REQ-039 reset asserted in WAIT_ADDR and in ISSUE -> all outputs at reset values next cycle, no request_error.
